// File: rtl/sim_trace_chk.sv
// Multi-lane retire-trace checker for co-simulation. Reference PCs from the ISS are
// buffered in a FIFO and compared in program order against PCs retired by the core.
// Captures the first mismatching pair per cycle, counts mismatches and halts after a
// configurable miss budget.
module sim_trace_chk #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned RETIRE_W = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned MAX_MISS = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     ref_valid,
  input  logic [XLEN-1:0]          ref_pc,
  output logic                     ref_ready,
  input  logic [RETIRE_W-1:0]      ret_valid,
  input  logic [RETIRE_W*XLEN-1:0] ret_pc,
  output logic                     miss,
  output logic [XLEN-1:0]          miss_pc_try,
  output logic [XLEN-1:0]          miss_pc_factual,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic                     err_underflow,
  output logic                     err_order,
  output logic                     halt
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntFW = PtrW + 1;
  localparam int unsigned LaneW = $clog2(RETIRE_W + 1);

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e               state_q, state_d;
  logic [XLEN-1:0]      mem_q [DEPTH];
  logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CntFW-1:0]     count_q, count_d;
  logic                 ref_ready_q, ref_ready_d;
  logic                 miss_q, miss_d;
  logic [XLEN-1:0]      try_q, try_d, fact_q, fact_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 uf_q, uf_d, ord_q, ord_d;

  logic                 run, thermo, do_push, do_ret, underflow, found;
  logic [LaneW-1:0]     n_lanes, m_cnt;
  logic [CntFW-1:0]     n_cmp;
  logic [PtrW-1:0]      rd_idx;
  logic [XLEN-1:0]      exp_pc, act_pc;
  logic [CNT_W:0]       cnt_sum;

  // Next-state: retire compare, FIFO pointer bookkeeping, capture and FSM transition.
  always_comb begin
    run     = (state_q == StRun);
    n_lanes = '0;
    thermo  = 1'b1;
    for (int i = 0; i < int'(RETIRE_W); i++) begin
      n_lanes = n_lanes + LaneW'(ret_valid[i]);
      if (i > 0 && ret_valid[i] && !ret_valid[i-1]) thermo = 1'b0;
    end

    do_push   = run && !flush && ref_valid && ref_ready_q;
    do_ret    = run && !flush && thermo && (n_lanes != '0);
    underflow = do_ret && (CntFW'(n_lanes) > count_q);
    // Lanes actually compared and popped; capped at what the FIFO holds.
    if (!do_ret)        n_cmp = '0;
    else if (underflow) n_cmp = count_q;
    else                n_cmp = CntFW'(n_lanes);

    m_cnt  = '0;
    found  = 1'b0;
    try_d  = try_q;
    fact_d = fact_q;
    rd_idx = '0;
    exp_pc = '0;
    act_pc = '0;
    for (int i = 0; i < int'(RETIRE_W); i++) begin
      rd_idx = head_q + PtrW'(i);
      exp_pc = mem_q[rd_idx];
      act_pc = ret_pc[i*XLEN +: XLEN];
      if (CntFW'(i) < n_cmp && act_pc != exp_pc) begin
        m_cnt = m_cnt + LaneW'(1);
        if (!found) begin
          found  = 1'b1;
          try_d  = act_pc;
          fact_d = exp_pc;
        end
      end
    end

    head_d  = head_q + PtrW'(n_cmp);
    tail_d  = tail_q + PtrW'(do_push);
    count_d = count_q + CntFW'(do_push) - n_cmp;
    if (run && flush) begin
      head_d  = tail_q;
      count_d = '0;
    end

    uf_d   = uf_q | underflow;
    ord_d  = ord_q | (run && !flush && !thermo);
    miss_d = (m_cnt != '0);

    cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(m_cnt);
    cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];

    state_d = state_q;
    if (run && cnt_d >= CNT_W'(MAX_MISS)) state_d = StHalt;
    ref_ready_d = (state_d == StRun) && (count_d < CntFW'(DEPTH));
  end

  // Control and capture state; all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ref_ready_q <= 1'b0;
      miss_q      <= 1'b0;
      try_q       <= '0;
      fact_q      <= '0;
      cnt_q       <= '0;
      uf_q        <= 1'b0;
      ord_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ref_ready_q <= ref_ready_d;
      miss_q      <= miss_d;
      try_q       <= try_d;
      fact_q      <= fact_d;
      cnt_q       <= cnt_d;
      uf_q        <= uf_d;
      ord_q       <= ord_d;
    end
  end

  // Reference storage; contents are only meaningful between head and tail, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= ref_pc;
  end

  assign ref_ready       = ref_ready_q;
  assign miss            = miss_q;
  assign miss_pc_try     = try_q;
  assign miss_pc_factual = fact_q;
  assign miss_cnt        = cnt_q;
  assign err_underflow   = uf_q;
  assign err_order       = ord_q;
  assign halt            = (state_q == StHalt);

endmodule
